// File: rtl/uart_rx_err_ctrl.sv
// UART RX error-manager sequencer: capture cause, raise IRQ, wait for ACK or auto-clear,
// pulse error_clear, then hold off. Per-type error counters compiled with UART_RX_ERR_CNT_EN.
module uart_rx_err_ctrl #(
   parameter int HOLDOFF_CYCLES = 4
`ifdef UART_RX_ERR_CNT_EN
   ,
   parameter int CNT_W = 8
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       err_flags_i,
   input  logic [3:0]       irq_mask_i,
   input  logic             auto_clear_i,
   input  logic             ack_i,
   output logic             error_clear_o,
   output logic             irq_o,
   output logic [3:0]       err_cause_o,
   output logic             overrun_o,
   output logic             busy_o
`ifdef UART_RX_ERR_CNT_EN
   ,
   input  logic             cnt_clr_i,
   output logic [4*CNT_W-1:0] cnt_o
`endif
);

   localparam int HW = $clog2(HOLDOFF_CYCLES);
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, PEND, CLEAR, HOLD} state_e;

   state_e          state_q;
   logic [3:0]      prevFlags_q;
   logic [3:0]      cause_q;
   logic            overrun_q;
   logic            irq_q;
   logic            clear_q;
   logic            busy_q;
   logic [HW-1:0]   hold_q;

   logic [3:0]      rise;
   logic [3:0]      live;
   logic [3:0]      riseLive;

   assign rise     = err_flags_i & ~prevFlags_q;
   assign live     = err_flags_i & ~irq_mask_i;
   assign riseLive = rise & ~irq_mask_i;

   // Outputs are registered alongside the state so every transition sets them explicitly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         prevFlags_q <= '0;
         cause_q     <= '0;
         overrun_q   <= 1'b0;
         irq_q       <= 1'b0;
         clear_q     <= 1'b0;
         busy_q      <= 1'b0;
         hold_q      <= '0;
      end else begin
         prevFlags_q <= err_flags_i;
         case (state_q)
            IDLE: begin
               if (|live) begin
                  state_q   <= PEND;
                  cause_q   <= live;
                  overrun_q <= 1'b0;
                  irq_q     <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            PEND: begin
               cause_q <= cause_q | riseLive;
               if (|riseLive) begin
                  overrun_q <= 1'b1;
               end
               if (ack_i || auto_clear_i) begin
                  state_q <= CLEAR;
                  irq_q   <= 1'b0;
                  clear_q <= 1'b1;
               end
            end
            CLEAR: begin
               state_q <= HOLD;
               clear_q <= 1'b0;
               hold_q  <= HOLD_INIT;
            end
            HOLD: begin
               if (|riseLive) begin
                  overrun_q <= 1'b1;
               end
               if (hold_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  hold_q <= hold_q - 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               irq_q   <= 1'b0;
               clear_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign error_clear_o = clear_q;
   assign irq_o         = irq_q;
   assign err_cause_o   = cause_q;
   assign overrun_o     = overrun_q;
   assign busy_o        = busy_q;

`ifdef UART_RX_ERR_CNT_EN
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];

   // Saturating counters see every rising flag regardless of mask or state; clear beats increment.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
         if (cnt_clr_i) begin
            cnt_d[i] = '0;
         end else if (rise[i] && (cnt_q[i] != '1)) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign cnt_o = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule
